// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter fetch controller: FSM state
// encoding, instruction opcodes and default sizing.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_FWD = 2'b01;
    localparam logic [1:0] OP_BWD = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    localparam int DEFAULT_AW      = 16;
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/pc_ctrl_decode.sv
// Combinational opcode decode: turns the latched instruction into a single
// pc-block strobe plus offset, only while the controller is executing.
module pc_ctrl_decode
    import pc_ctrl_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic [15:0]   instr,
    input  logic          exec,
    output logic          inc,
    output logic          add,
    output logic          sub,
    output logic [AW-1:0] offset
);

    always_comb begin
        inc    = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        offset = '0;
        if (exec) begin
            case (instr[15:14])
                OP_NOP: inc = 1'b1;
                OP_FWD: begin
                    add    = 1'b1;
                    offset = AW'(instr[13:0]);
                end
                OP_BWD: begin
                    sub    = 1'b1;
                    offset = AW'(instr[13:0]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch/execute controller: requests instruction words at pc_in, latches them
// and issues one pc-block strobe per instruction, with a fetch timeout.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [AW-1:0] pc_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_data,
    output logic          inc,
    output logic          add,
    output logic          sub,
    output logic [AW-1:0] offset,
    output logic          halted,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [15:0]   instr;
    logic          started;
    logic          exec_en;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run && started) state_nxt = S_FETCH;
            S_FETCH: begin
                // ack in the timeout cycle still wins over the error
                if (imem_ack)
                    state_nxt = S_EXEC;
                else if (count == LAST_WAIT)
                    state_nxt = S_ERROR;
            end
            S_EXEC: begin
                if (instr[15:14] == OP_HLT)
                    state_nxt = S_HALT;
                else if (run)
                    state_nxt = S_FETCH;
                else
                    state_nxt = S_IDLE;
            end
            S_HALT:  if (!run) state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // started holds off the first fetch for one edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            count   <= '0;
            instr   <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (state == S_FETCH)
                count <= count + CW'(1);
            else
                count <= '0;
            if (state == S_FETCH && imem_ack)
                instr <= imem_data;
        end
    end

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = (state == S_FETCH) ? pc_in : '0;
    assign halted    = (state == S_HALT);
    assign err       = (state == S_ERROR);
    assign exec_en   = (state == S_EXEC);

    pc_ctrl_decode #(
        .AW(AW)
    ) u_decode (
        .instr (instr),
        .exec  (exec_en),
        .inc   (inc),
        .add   (add),
        .sub   (sub),
        .offset(offset)
    );

endmodule
